// File: rtl/de_regfile_sb_if.sv
// Issue/writeback bundle for de_regfile_sb: the decoder drives the master side,
// the register file with scoreboard sits on the slave side.
interface de_regfile_sb_if #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5
);
  logic                 issue_valid;
  logic                 issue_wr;
  logic [REGNOBITS-1:0] issue_rd;
  logic [REGNOBITS-1:0] rs1;
  logic [REGNOBITS-1:0] rs2;
  logic                 rs1_used;
  logic                 rs2_used;
  logic                 wb_wr;
  logic [REGNOBITS-1:0] wb_rd;
  logic [DBITS-1:0]     wb_val;
  logic                 flush;
  logic [DBITS-1:0]     rs1_val;
  logic [DBITS-1:0]     rs2_val;
  logic                 stall;
  logic                 issue_fire;
  logic                 pending_any;

  modport master (
    output issue_valid, issue_wr, issue_rd, rs1, rs2, rs1_used, rs2_used,
    output wb_wr, wb_rd, wb_val, flush,
    input  rs1_val, rs2_val, stall, issue_fire, pending_any
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd, rs1, rs2, rs1_used, rs2_used,
    input  wb_wr, wb_rd, wb_val, flush,
    output rs1_val, rs2_val, stall, issue_fire, pending_any
  );
endinterface

// File: rtl/de_regfile_sb.sv
// Decode-stage register file with a per-register in-flight writer scoreboard.
// Define DE_RF_BYPASS_EN to forward same-cycle writeback data and release the last pending writer.
module de_regfile_sb #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGWORDS  = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CNTBITS   = 2
) (
  input logic            clk,
  input logic            reset,
  de_regfile_sb_if.slave bus
);

  localparam logic [CNTBITS-1:0] CntMax = '1;
  localparam logic [CNTBITS-1:0] CntOne = CNTBITS'(1);

  logic [DBITS-1:0]   regs_q [REGWORDS];
  logic [DBITS-1:0]   regs_d [REGWORDS];
  logic [CNTBITS-1:0] cnt_q  [REGWORDS];
  logic [CNTBITS-1:0] cnt_d  [REGWORDS];

  logic                wb_en;
  logic                wb_hit1, wb_hit2;
  logic                rs1_pend, rs2_pend;
  logic                rd_full;
  logic                stall;
  logic                fire;
  logic [REGWORDS-1:0] inc_vec, dec_vec;
  logic                pending_any;

  assign wb_en   = bus.wb_wr && (bus.wb_rd != '0);
  assign wb_hit1 = wb_en && (bus.wb_rd == bus.rs1);
  assign wb_hit2 = wb_en && (bus.wb_rd == bus.rs2);

  // Source operands and pending status, optionally seeing the in-progress writeback.
  always_comb begin
    rs1_pend    = cnt_q[bus.rs1] != '0;
    rs2_pend    = cnt_q[bus.rs2] != '0;
    bus.rs1_val = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
    bus.rs2_val = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
`ifdef DE_RF_BYPASS_EN
    if (wb_hit1) begin
      bus.rs1_val = bus.wb_val;
      if (cnt_q[bus.rs1] == CntOne) rs1_pend = 1'b0;
    end
    if (wb_hit2) begin
      bus.rs2_val = bus.wb_val;
      if (cnt_q[bus.rs2] == CntOne) rs2_pend = 1'b0;
    end
`endif
  end

  assign rd_full = cnt_q[bus.issue_rd] == CntMax;

  assign stall = bus.issue_valid &&
                 ((bus.rs1_used && rs1_pend) ||
                  (bus.rs2_used && rs2_pend) ||
                  (bus.issue_wr && rd_full));
  assign fire  = bus.issue_valid && !stall;

  assign bus.stall      = stall;
  assign bus.issue_fire = fire;

  // Register 0 never gets a counter event, so it can never become pending.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < int'(REGWORDS); i++) begin
      inc_vec[i] = fire && bus.issue_wr && (bus.issue_rd == REGNOBITS'(i));
      dec_vec[i] = bus.wb_wr && (bus.wb_rd == REGNOBITS'(i)) && (cnt_q[i] != '0);
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[bus.wb_rd] = bus.wb_val;
  end

  // Simultaneous increment and decrement cancel; flush wins over a same-cycle issue.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(REGWORDS); i++) begin
      if (bus.flush || (i == 0)) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REGWORDS); i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < int'(REGWORDS); i++) begin
      pending_any = pending_any | (cnt_q[i] != '0);
    end
  end

  assign bus.pending_any = pending_any;

endmodule

// File: doc/de_regfile_sb.md
DE_REGFILE_SB -- requirements
Module: de_regfile_sb

Interface
REQ-001 SHALL have parameter DBITS, default 32, data width of each register.
REQ-002 SHALL have parameter REGWORDS, default 32, number of architectural registers.
REQ-003 SHALL have parameter REGNOBITS, default 5, register index width.
REQ-004 SHALL have parameter CNTBITS, default 2, width of each per-register pending counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port issue_valid, input, 1, a decoded instruction is presented.
REQ-008 SHALL have port issue_wr, input, 1, the presented instruction writes rd.
REQ-009 SHALL have port issue_rd, input, REGNOBITS, destination index.
REQ-010 SHALL have ports rs1/rs2, input, REGNOBITS each, source indices.
REQ-011 SHALL have ports rs1_used/rs2_used, input, 1 each, the source is actually read.
REQ-012 SHALL have ports wb_wr, input, 1; wb_rd, input, REGNOBITS; wb_val, input, DBITS: writeback request.
REQ-013 SHALL have port flush, input, 1, clear all pending state.
REQ-014 SHALL have ports rs1_val/rs2_val, output, DBITS each, source operands.
REQ-015 SHALL have port stall, output, 1, issue blocked this cycle.
REQ-016 SHALL have port issue_fire, output, 1, equal to issue_valid && !stall.
REQ-017 SHALL have port pending_any, output, 1, at least one counter is nonzero.

Function
- REQ-018 SHALL hold REGWORDS x DBITS registers; the write on a rising edge when wb_wr && wb_rd != 0.
- REQ-019 SHALL read register 0 as zero, never mark it pending, and ignore writes to it.
- REQ-020 SHALL drive rs1_val/rs2_val combinationally from the array (post-edge contents).
- REQ-021 SHALL keep one saturating CNTBITS counter per register, counting in-flight writers.
- REQ-022 SHALL increment cnt[issue_rd] on the edge where issue_fire && issue_wr && issue_rd != 0.
- REQ-023 SHALL decrement cnt[wb_rd] on the edge where wb_wr && wb_rd != 0 && cnt[wb_rd] != 0; decrement of a zero counter SHALL be ignored.
- REQ-024 SHALL leave a counter unchanged when it is both incremented and decremented in the same cycle.
- REQ-025 SHALL assert stall when issue_valid and any of: rs1_used && pend(rs1); rs2_used && pend(rs2); issue_wr && cnt[issue_rd] == 2^CNTBITS-1.
- REQ-026 SHALL define pend(r) = cnt[r] != 0 (without bypass, see Configuration).
- REQ-027 SHALL, on flush, zero all counters on that edge, ignoring same-cycle increments; the same-cycle register write SHALL still occur.
- REQ-028 SHALL assert stall = 0 and issue_fire = 0 while issue_valid = 0, regardless of counters.
- REQ-029 SHALL derive pending_any from registered counter state (no combinational input path).

Reset
- REQ-030 SHALL, on a reset edge, zero all registers and all counters; reset SHALL override flush, issue and writeback in that cycle.
- REQ-031 SHALL present rs*_val = 0, pending_any = 0 in the cycle after reset; stall follows REQ-025 with zeroed counters.

Configuration
- REQ-032 SHALL use macro DE_RF_BYPASS_EN to select writeback bypass.
- REQ-033 SHALL, with DE_RF_BYPASS_EN defined, forward wb_val to rs1_val/rs2_val when wb_wr && wb_rd == rs* && rs* != 0, and treat pend(r) as false when cnt[r] == 1 && wb_wr && wb_rd == r.
- REQ-034 SHALL, without DE_RF_BYPASS_EN, provide no forwarding; a source written this cycle stalls until the following cycle.

Verification
- REQ-035 SHALL cover: issue ADD rd=5 (fire), next cycle issue rs1=5 used -> stall=1 until wb_wr rd=5 val=0x1234; then rs1_val=0x1234, stall=0.
- REQ-036 SHALL cover: with CNTBITS=2, three fires writing rd=7, fourth issue_wr rd=7 -> stall=1; one wb rd=7 -> fourth fires next cycle.
- REQ-037 SHALL cover: same cycle fire rd=3 and wb rd=3 with cnt[3]=1 -> cnt[3] stays 1, pending_any=1.
- REQ-038 SHALL cover: wb_wr rd=0 val=0xFFFFFFFF, issue rd=0 -> rs1_val(0)=0, no stall, pending_any unchanged.
- REQ-039 SHALL cover: two pending regs then flush -> pending_any=0 next cycle; later wb to a flushed reg -> value written, counter stays 0.
- REQ-040 SHALL cover: with DE_RF_BYPASS_EN, cnt[9]=1, wb rd=9 val=0xAB with issue rs2=9 used -> stall=0, rs2_val=0xAB same cycle; without macro -> stall=1 that cycle.
